// File: rtl/ysyx_24110006_clint.sv
// ysyx_24110006_clint -- read-only CLINT exposing the 64-bit mtime counter
// over a minimal AXI4-Lite read channel.
//
// Parameters:
//   BASE       address of mtime[31:0]; mtime[63:32] (via shadow) at BASE+4
//   TICK_DIV   clock cycles per mtime increment, 1..65535
//   MTIME_INIT value mtime takes while in reset (0 for a standard CLINT)
//
// Ports:
//   i_clock, i_reset_n          clock, async active-low reset
//   i_axi_araddr/arvalid/arready  read address channel
//   o_axi_rdata/rresp/rvalid, i_axi_rready  read data channel
//
// Reading the low word snapshots the high word into a shadow register, so a
// low-then-high read pair always returns a coherent 64-bit value even if a
// carry into bit 32 happens between the two reads.
module ysyx_24110006_clint #(
    parameter logic [31:0] BASE       = 32'h0200_0000,
    parameter int unsigned TICK_DIV   = 1,
    parameter logic [63:0] MTIME_INIT = 64'h0
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic [31:0] i_axi_araddr,
    input  logic        i_axi_arvalid,
    output logic        o_axi_arready,
    output logic [31:0] o_axi_rdata,
    output logic        o_axi_rvalid,
    output logic [1:0]  o_axi_rresp,
    input  logic        i_axi_rready
);

    localparam logic [15:0] DIV_LAST    = 16'(TICK_DIV - 1);
    localparam logic [31:0] ADDR_HI     = BASE + 32'd4;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic {ST_IDLE, ST_RESP} state_e;

    state_e      state_q,  state_d;
    logic [15:0] pre_q,    pre_d;
    logic [63:0] mtime_q,  mtime_d;
    logic [31:0] shadow_q, shadow_d;
    logic [31:0] rdata_q,  rdata_d;
    logic [1:0]  rresp_q,  rresp_d;

    // Free-running timebase, independent of the bus FSM.
    always_comb begin
        pre_d   = pre_q + 16'd1;
        mtime_d = mtime_q;
        if (pre_q == DIV_LAST) begin
            pre_d   = 16'd0;
            mtime_d = mtime_q + 64'd1;
        end
    end

    // Read FSM: data is captured from the pre-increment mtime of the
    // handshake cycle and held until the R handshake.
    always_comb begin
        state_d       = state_q;
        shadow_d      = shadow_q;
        rdata_d       = rdata_q;
        rresp_d       = rresp_q;
        o_axi_arready = 1'b0;
        o_axi_rvalid  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                o_axi_arready = 1'b1;
                if (i_axi_arvalid) begin
                    state_d = ST_RESP;
                    if (i_axi_araddr == BASE) begin
                        rdata_d  = mtime_q[31:0];
                        shadow_d = mtime_q[63:32];
                        rresp_d  = RESP_OKAY;
                    end else if (i_axi_araddr == ADDR_HI) begin
                        rdata_d  = shadow_q;
                        rresp_d  = RESP_OKAY;
                    end else begin
                        rdata_d  = 32'h0;
                        rresp_d  = RESP_SLVERR;
                    end
                end
            end
            ST_RESP: begin
                o_axi_rvalid = 1'b1;
                if (i_axi_rready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= ST_IDLE;
            pre_q    <= 16'd0;
            mtime_q  <= MTIME_INIT;
            shadow_q <= 32'h0;
            rdata_q  <= 32'h0;
            rresp_q  <= RESP_OKAY;
        end else begin
            state_q  <= state_d;
            pre_q    <= pre_d;
            mtime_q  <= mtime_d;
            shadow_q <= shadow_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
        end
    end

    assign o_axi_rdata = rdata_q;
    assign o_axi_rresp = rresp_q;

endmodule

// File: tb/tb_ysyx_24110006_clint.sv
// Self-checking bench for ysyx_24110006_clint. Four instances share one bus
// stimulus and differ in TICK_DIV / reset value of mtime; a transaction-level
// model predicts every response from mtime = init + edges_since_reset/div.
module tb_ysyx_24110006_clint;

    localparam logic [31:0] BASE = 32'h0200_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] araddr = 32'h0;
    logic        arvalid = 1'b0;
    logic        rready = 1'b1;

    logic        arready [4];
    logic        rvalid  [4];
    logic [31:0] rdata   [4];
    logic [1:0]  rresp   [4];

    int unsigned div  [4] = '{1, 4, 1, 4};
    logic [63:0] init [4] = '{64'h0, 64'h0, 64'h0000_0001_FFFF_FFFF, ONES};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_24110006_clint #(.BASE(BASE), .TICK_DIV(1), .MTIME_INIT(64'h0)) u0 (
        .i_clock(clk), .i_reset_n(rst_n), .i_axi_araddr(araddr), .i_axi_arvalid(arvalid),
        .o_axi_arready(arready[0]), .o_axi_rdata(rdata[0]), .o_axi_rvalid(rvalid[0]),
        .o_axi_rresp(rresp[0]), .i_axi_rready(rready));
    ysyx_24110006_clint #(.BASE(BASE), .TICK_DIV(4), .MTIME_INIT(64'h0)) u1 (
        .i_clock(clk), .i_reset_n(rst_n), .i_axi_araddr(araddr), .i_axi_arvalid(arvalid),
        .o_axi_arready(arready[1]), .o_axi_rdata(rdata[1]), .o_axi_rvalid(rvalid[1]),
        .o_axi_rresp(rresp[1]), .i_axi_rready(rready));
    ysyx_24110006_clint #(.BASE(BASE), .TICK_DIV(1), .MTIME_INIT(64'h0000_0001_FFFF_FFFF)) u2 (
        .i_clock(clk), .i_reset_n(rst_n), .i_axi_araddr(araddr), .i_axi_arvalid(arvalid),
        .o_axi_arready(arready[2]), .o_axi_rdata(rdata[2]), .o_axi_rvalid(rvalid[2]),
        .o_axi_rresp(rresp[2]), .i_axi_rready(rready));
    ysyx_24110006_clint #(.BASE(BASE), .TICK_DIV(4), .MTIME_INIT(ONES)) u3 (
        .i_clock(clk), .i_reset_n(rst_n), .i_axi_araddr(araddr), .i_axi_arvalid(arvalid),
        .o_axi_arready(arready[3]), .o_axi_rdata(rdata[3]), .o_axi_rvalid(rvalid[3]),
        .o_axi_rresp(rresp[3]), .i_axi_rready(rready));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    longint unsigned n = 0;          // rising edges seen with reset released
    bit          pending = 1'b0;     // a response is owed
    logic [31:0] m_data   [4];
    logic [1:0]  m_resp   [4];
    logic [31:0] m_shadow [4];

    function automatic logic [63:0] mtime_at(input int i);
        return init[i] + 64'(n / longint'(div[i]));
    endfunction

    initial begin
        for (int i = 0; i < 4; i++) begin
            m_data[i] = 0; m_resp[i] = 0; m_shadow[i] = 0;
        end
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                n = 0;
                pending = 1'b0;
                for (int i = 0; i < 4; i++) m_shadow[i] = 0;
            end else if (clk) begin
                if (!pending && arvalid) begin
                    pending = 1'b1;
                    for (int i = 0; i < 4; i++) begin
                        logic [63:0] m;
                        m = mtime_at(i);
                        if (araddr == BASE) begin
                            m_data[i] = m[31:0]; m_shadow[i] = m[63:32]; m_resp[i] = 2'b00;
                        end else if (araddr == BASE + 32'd4) begin
                            m_data[i] = m_shadow[i]; m_resp[i] = 2'b00;
                        end else begin
                            m_data[i] = 32'h0; m_resp[i] = 2'b10;
                        end
                    end
                end else if (pending && rready) begin
                    pending = 1'b0;
                end
                n++;
            end
        end
    end

    // ---------------- compare process ----------------
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (!rst_n) begin
                    chk("rst_arready", 64'(arready[i]), 64'd1);
                    chk("rst_rvalid",  64'(rvalid[i]),  64'd0);
                    chk("rst_rdata",   64'(rdata[i]),   64'd0);
                    chk("rst_rresp",   64'(rresp[i]),   64'd0);
                end else begin
                    chk("arready", 64'(arready[i]), 64'(!pending));
                    chk("rvalid",  64'(rvalid[i]),  64'(pending));
                    if (pending) begin
                        chk("rdata", 64'(rdata[i]), 64'(m_data[i]));
                        chk("rresp", 64'(rresp[i]), 64'(m_resp[i]));
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // ---------------- stimulus ----------------
    // All tasks start and end at a falling edge.
    task automatic rd_start(input logic [31:0] a);
        #1 araddr = a; arvalid = 1'b1;
        @(negedge clk);
    endtask

    task automatic rd_end();
        #1 arvalid = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0; arvalid = 1'b0; rready = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic read_after(input int cycles);
        do_reset();
        #1 rst_n = 1'b1;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        rd_start(BASE);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        // Read BASE in the very first released cycle, then the shadow word.
        #1 rst_n = 1'b1; araddr = BASE; arvalid = 1'b1;
        @(negedge clk);
        chk("lo_pre_u2", 64'(rdata[2]), 64'hFFFF_FFFF);
        chk("lo_pre_u3", 64'(rdata[3]), 64'hFFFF_FFFF);
        chk("lo_pre_u0", 64'(rdata[0]), 64'h0);
        rd_end();
        rd_start(BASE + 32'd4);
        chk("shadow_u2", 64'(rdata[2]), 64'h1);
        chk("shadow_u3", 64'(rdata[3]), 64'hFFFF_FFFF);
        rd_end();
        rd_start(BASE + 32'd8);
        chk("bad_rdata", 64'(rdata[0]), 64'h0);
        chk("bad_rresp", 64'(rresp[0]), 64'h2);
        rd_end();
        rd_start(BASE + 32'd4);
        chk("shadow_kept", 64'(rdata[2]), 64'h1);
        rd_end();

        // Backpressure: 8 edges elapsed, hold rready low with a new address pending.
        rready = 1'b0;
        rd_start(BASE);
        #1 araddr = BASE + 32'd4;
        repeat (5) begin
            @(negedge clk);
            chk("bp_arready", 64'(arready[0]), 64'd0);
            chk("bp_rdata_u0", 64'(rdata[0]), 64'd8);
            chk("bp_rdata_u2", 64'(rdata[2]), 64'd7);
        end
        #1 rready = 1'b1;
        @(negedge clk);
        chk("bp_idle_rvalid", 64'(rvalid[0]), 64'd0);
        @(negedge clk);
        chk("bp_next_rvalid", 64'(rvalid[2]), 64'd1);
        chk("bp_next_shadow", 64'(rdata[2]), 64'd2);
        rd_end();

        // Cycle-10 read, TICK_DIV=1 and 4.
        read_after(10);
        chk("c10_u0", 64'(rdata[0]), 64'd10);
        chk("c10_u1", 64'(rdata[1]), 64'd2);
        chk("c10_u3", 64'(rdata[3]), 64'd1);
        rd_end();
        chk("c12_arready", 64'(arready[0]), 64'd1);
        chk("c12_rvalid", 64'(rvalid[0]), 64'd0);

        read_after(20);
        chk("c20_u1", 64'(rdata[1]), 64'd5);
        chk("c20_u0", 64'(rdata[0]), 64'd20);
        rd_end();

        // One tick of TICK_DIV=4 from all-ones wraps to zero.
        read_after(4);
        chk("wrap_lo", 64'(rdata[3]), 64'd0);
        rd_end();
        rd_start(BASE + 32'd4);
        chk("wrap_hi", 64'(rdata[3]), 64'd0);
        rd_end();

        // Reset in the middle of a pending response.
        rready = 1'b0;
        rd_start(BASE);
        chk("mid_rvalid_pre", 64'(rvalid[0]), 64'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rvalid", 64'(rvalid[0]), 64'd0);
        chk("mid_arready", 64'(arready[0]), 64'd1);
        chk("mid_rdata", 64'(rdata[0]), 64'd0);
        arvalid = 1'b0; rready = 1'b1;
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rvalid", 64'(rvalid[0]), 64'd0);
        rd_start(BASE);
        chk("restart_u0", 64'(rdata[0]), 64'd1);
        rd_end();

        // Randomized traffic with occasional resets.
        repeat (600) begin
            #1;
            arvalid = 1'($urandom_range(0, 1));
            rready  = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: araddr = BASE;
                1: araddr = BASE + 32'd4;
                2: araddr = BASE + 32'd8;
                default: araddr = $urandom;
            endcase
            rst_n = ($urandom_range(0, 59) != 0);
            @(negedge clk);
        end
        #1 rst_n = 1'b1; arvalid = 1'b0; rready = 1'b1;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_24110006_clint.md
YSYX_24110006_CLINT -- requirements
Module: ysyx_24110006_clint

Interface
REQ-001 Parameter BASE, default 32'h02000000, base address of the mtime window (low word at BASE, high word at BASE+4).
REQ-002 Parameter TICK_DIV, default 1, number of clock cycles per mtime increment; legal range 1..65535.
REQ-003 Port i_clock  input  1  sole clock; all state is updated on its rising edge.
REQ-004 Port i_reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port i_axi_araddr  input  32  read address from the crossbar CLINT port.
REQ-006 Port i_axi_arvalid  input  1  read address valid.
REQ-007 Port o_axi_arready  output  1  read address ready.
REQ-008 Port o_axi_rdata  output  32  read data.
REQ-009 Port o_axi_rvalid  output  1  read data valid.
REQ-010 Port o_axi_rresp  output  2  read response: 2'b00 OKAY, 2'b10 SLVERR.
REQ-011 Port i_axi_rready  input  1  read data ready.

Function
REQ-012 mtime SHALL be a 64-bit free-running counter.
REQ-013 A prescale counter SHALL count 0..TICK_DIV-1; mtime SHALL increment by 1 in the cycle the prescale counter equals TICK_DIV-1, and the prescale counter SHALL return to 0 in that cycle.
REQ-014 With TICK_DIV=1, mtime SHALL increment every cycle.
REQ-015 mtime SHALL wrap from 64'hFFFF_FFFF_FFFF_FFFF to 0 with no flag or stall.
REQ-016 The FSM SHALL have two states: IDLE and RESP.
REQ-017 In IDLE, o_axi_arready SHALL be 1 and o_axi_rvalid SHALL be 0.
REQ-018 In RESP, o_axi_arready SHALL be 0 and o_axi_rvalid SHALL be 1.
REQ-019 An AR handshake (i_axi_arvalid & o_axi_arready) SHALL move the FSM from IDLE to RESP and latch o_axi_rdata and o_axi_rresp in the same edge.
REQ-020 Read latency SHALL be exactly one cycle: o_axi_rvalid rises on the edge after the AR handshake.
REQ-021 A read of araddr == BASE SHALL return the mtime[31:0] value present in the handshake cycle, before that cycle's increment.
REQ-022 The same low-word read SHALL also copy that cycle's mtime[63:32] into a 32-bit shadow register.
REQ-023 A read of araddr == BASE+4 SHALL return the shadow register, with rresp 2'b00.
REQ-024 Any other araddr SHALL return rdata 32'h0 with rresp 2'b10 and SHALL NOT modify the shadow register.
REQ-025 In RESP, o_axi_rdata and o_axi_rresp SHALL stay stable until i_axi_rready is 1.
REQ-026 The R handshake (o_axi_rvalid & i_axi_rready) SHALL return the FSM to IDLE; back-to-back reads SHALL therefore take at least 2 cycles each.
REQ-027 i_axi_arvalid asserted while in RESP SHALL be ignored until IDLE, and the address SHALL be sampled only at the handshake.
REQ-028 The mtime counter SHALL keep counting independent of FSM state and of rready backpressure.
REQ-029 No write channel exists; the crossbar never routes writes here.

Reset
REQ-030 While i_reset_n is 0, the following SHALL be cleared asynchronously: mtime, prescale counter and shadow to 0; FSM to IDLE; o_axi_rdata to 0; o_axi_rresp to 2'b00; o_axi_rvalid to 0.
REQ-031 o_axi_arready SHALL be 1 during reset, following the IDLE state.
REQ-032 Reset asserted in RESP SHALL abandon the pending response with no R beat after release.
REQ-033 The first increment after reset release SHALL occur TICK_DIV cycles after the first rising edge with i_reset_n=1.

Verification
REQ-034 TICK_DIV=1, reset release, read BASE at cycle 10 with rready=1 -> rvalid=1 in cycle 11, rdata=10, rresp=0, FSM back to IDLE in cycle 12.
REQ-035 Preload mtime=64'h0000_0001_FFFF_FFFF, read BASE then BASE+4 -> rdata 32'hFFFF_FFFF then 32'h0000_0001 (shadow), although live mtime[63:32] is now 2.
REQ-036 Read 32'h02000008 -> rdata 0, rresp 2'b10, shadow unchanged.
REQ-037 Hold rready=0 for 5 cycles with arvalid held high to a new address -> rdata/rresp stable, arready=0, new address accepted only in the cycle after the R handshake.
REQ-038 TICK_DIV=4, run 20 cycles after release, read low word -> rdata=5; preload all-ones and tick once -> mtime wraps to 0.
REQ-039 Assert i_reset_n=0 mid-RESP, release -> rvalid=0, arready=1, mtime restarts from 0.
